// File: rtl/io_port_responder.sv
// Peripheral end of the CU I/O handshake: debounced "enter" button with switch
// capture on the input side, latched display word with four 7-segment digits on the output side.
module io_port_responder #(
    parameter int unsigned SW_W            = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned SIGN_EXT        = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            btn_raw,
    input  logic [SW_W-1:0] switches,
    input  logic            in_req,
    output logic            enter,
    output logic [31:0]     in_data,
    input  logic            display_write,
    input  logic [31:0]     display_data,
    output logic [31:0]     display_value,
    output logic            display_valid,
    output logic [6:0]      hex0,
    output logic [6:0]      hex1,
    output logic [6:0]      hex2,
    output logic [6:0]      hex3
);
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ARMED    = 2'd1;
    localparam logic [1:0] FIRE     = 2'd2;
    localparam logic [1:0] WAIT_REL = 2'd3;

    logic             s1, s2;
    logic             btn_db, btn_db_q;
    logic [CNT_W-1:0] db_cnt;
    logic             rise;
    logic [1:0]       state, state_nxt;
    logic [31:0]      sw_ext;
    logic             capture;

    // Two-flop synchronizer for the asynchronous button
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
            db_cnt   <= '0;
        end else begin
            btn_db_q <= btn_db;
            if (s2 == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                btn_db <= s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + CNT_W'(1);
            end
        end
    end

    assign rise = btn_db & ~btn_db_q;

    always_comb begin
        sw_ext = 32'(switches);
        if (SIGN_EXT != 0 && switches[SW_W-1]) begin
            for (int i = SW_W; i < 32; i++) sw_ext[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // A rise while armed fires even if in_req drops on the same edge
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (in_req) state_nxt = ARMED;
            ARMED: begin
                if (rise)         state_nxt = FIRE;
                else if (!in_req) state_nxt = IDLE;
            end
            FIRE:     state_nxt = WAIT_REL;
            WAIT_REL: if (!btn_db) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    assign capture = (state == ARMED) && rise;
    assign enter   = (state == FIRE);

    always_ff @(posedge clk) begin
        if (reset) begin
            in_data       <= '0;
            display_value <= '0;
            display_valid <= 1'b0;
        end else begin
            if (capture) in_data <= sw_ext;
            if (display_write) begin
                display_value <= display_data;
                display_valid <= 1'b1;
            end
        end
    end

    // Active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    assign hex0 = seg7(display_value[3:0]);
    assign hex1 = seg7(display_value[7:4]);
    assign hex2 = seg7(display_value[11:8]);
    assign hex3 = seg7(display_value[15:12]);
endmodule

// File: tb/tb_io_port_responder.sv
// Scoreboard bench: two responders (zero- and sign-extending) share stimulus;
// expected enter pulses are queued with their cycle and captured words.
module tb_io_port_responder;
    localparam int unsigned DB = 4;

    logic        clk, reset, btn_raw, in_req, display_write;
    logic [15:0] switches;
    logic [31:0] display_data;

    logic        enter0, enter1, valid0, valid1;
    logic [31:0] in_data0, in_data1, value0, value1;
    logic [6:0]  h00, h01, h02, h03, h10, h11, h12, h13;

    io_port_responder #(.SW_W(16), .DEBOUNCE_CYCLES(DB), .SIGN_EXT(0)) dut0 (
        .clk(clk), .reset(reset), .btn_raw(btn_raw), .switches(switches),
        .in_req(in_req), .enter(enter0), .in_data(in_data0),
        .display_write(display_write), .display_data(display_data),
        .display_value(value0), .display_valid(valid0),
        .hex0(h00), .hex1(h01), .hex2(h02), .hex3(h03));

    io_port_responder #(.SW_W(16), .DEBOUNCE_CYCLES(DB), .SIGN_EXT(1)) dut1 (
        .clk(clk), .reset(reset), .btn_raw(btn_raw), .switches(switches),
        .in_req(in_req), .enter(enter1), .in_data(in_data1),
        .display_write(display_write), .display_data(display_data),
        .display_value(value1), .display_valid(valid1),
        .hex0(h10), .hex1(h11), .hex2(h12), .hex3(h13));

    typedef struct {
        int unsigned cyc;
        logic [31:0] d0;
        logic [31:0] d1;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int          tests = 0;
    int          fails = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Press now; enter is due 2 sync + DB debounce + 1 FSM edges later
    task automatic press_expect(input logic [15:0] sw, input logic [31:0] e0, input logic [31:0] e1);
        exp_t e;
        switches = sw;
        btn_raw  = 1'b1;
        e.cyc = cyc + 2 + DB + 1;
        e.d0  = e0;
        e.d1  = e1;
        q.push_back(e);
    endtask

    // Monitor: every enter pulse must match the head of the queue
    always @(negedge clk) begin
        if (enter0 !== enter1) chk("enter_agree", 32'(enter1), 32'(enter0));
        if (enter0 === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_enter", 32'(enter0), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("enter_cycle", cyc, e.cyc);
                chk("in_data_zext", in_data0, e.d0);
                chk("in_data_sext", in_data1, e.d1);
            end
        end
    end

    initial begin
        reset = 1'b1; btn_raw = 1'b1; display_write = 1'b1;
        display_data = 32'h1234_5678; in_req = 1'b0; switches = 16'h0;
        wait_cyc(3);
        chk("rst_enter", 32'(enter0), 32'd0);
        chk("rst_in_data0", in_data0, 32'd0);
        chk("rst_in_data1", in_data1, 32'd0);
        chk("rst_valid", 32'(valid0), 32'd0);
        chk("rst_value", value0, 32'd0);
        chk("rst_hex", {h03, h02, h01, h00}, {4{7'b1000000}});
        reset = 1'b0; btn_raw = 1'b0; display_write = 1'b0;
        wait_cyc(10);

        // Clean press while armed
        in_req = 1'b1;
        wait_cyc(2);
        press_expect(16'h00A5, 32'h0000_00A5, 32'h0000_00A5);
        wait_cyc(12);
        btn_raw = 1'b0;
        wait_cyc(12);
        chk("hold_in_data", in_data0, 32'h0000_00A5);

        // Bounce shorter than the debounce window
        switches = 16'h7777;
        for (int i = 0; i < 8; i++) begin
            btn_raw = ~btn_raw;
            wait_cyc(2);
        end
        btn_raw = 1'b0;
        wait_cyc(10);
        chk("bounce_in_data", in_data0, 32'h0000_00A5);

        // Press with no input request
        in_req = 1'b0;
        switches = 16'h1111;
        btn_raw = 1'b1;
        wait_cyc(12);
        btn_raw = 1'b0;
        wait_cyc(12);
        chk("noreq_in_data", in_data0, 32'h0000_00A5);

        // Button already held when armed, then release and press again
        switches = 16'h2222;
        btn_raw = 1'b1;
        wait_cyc(10);
        in_req = 1'b1;
        wait_cyc(8);
        chk("preheld_in_data", in_data0, 32'h0000_00A5);
        btn_raw = 1'b0;
        wait_cyc(12);
        press_expect(16'h8001, 32'h0000_8001, 32'hFFFF_8001);
        wait_cyc(12);
        btn_raw = 1'b0;
        wait_cyc(12);

        // in_req drops on the same edge the rise is taken
        press_expect(16'h0042, 32'h0000_0042, 32'h0000_0042);
        wait_cyc(2 + DB);
        in_req = 1'b0;
        wait_cyc(6);
        btn_raw = 1'b0;
        wait_cyc(12);

        // Display write and hex decode
        display_data = 32'h0000_BEEF; display_write = 1'b1;
        wait_cyc(1);
        display_write = 1'b0;
        chk("disp_value", value0, 32'h0000_BEEF);
        chk("disp_valid", 32'(valid0), 32'd1);
        chk("disp_hex3", 32'(h03), 32'(7'b0000011));
        chk("disp_hex2", 32'(h02), 32'(7'b0000110));
        chk("disp_hex1", 32'(h01), 32'(7'b0000110));
        chk("disp_hex0", 32'(h00), 32'(7'b0001110));

        // Back-to-back writes: last wins
        display_data = 32'h0000_1234; display_write = 1'b1;
        wait_cyc(1);
        display_data = 32'hCAFE_5678;
        wait_cyc(1);
        display_write = 1'b0;
        chk("b2b_value", value1, 32'hCAFE_5678);
        chk("b2b_hex", {h03, h02, h01, h00},
            {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000});

        // Reset clears everything again
        reset = 1'b1;
        wait_cyc(1);
        reset = 1'b0;
        chk("rst2_value", value0, 32'd0);
        chk("rst2_valid", 32'(valid0), 32'd0);
        chk("rst2_in_data", in_data1, 32'd0);
        chk("rst2_hex", {h03, h02, h01, h00}, {4{7'b1000000}});

        wait_cyc(4);
        chk("missing_enter", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
